// File: rtl/bcd_countdown_if.sv
// -----------------------------------------------------------------------------
// bcd_countdown_if
// Groups the control strobes, start value and status outputs of the BCD
// countdown timer.
//   master : drives tick/load/start/pause/data, observes count/running/zero/done
//   slave  : the counter itself (consumes controls, produces status)
// Parameter DIGITS sets the number of packed BCD digits (data/count width
// is 4*DIGITS). Digit 0 occupies bits [3:0].
// -----------------------------------------------------------------------------
interface bcd_countdown_if #(
    parameter int DIGITS = 4
);
    logic                  tick;
    logic                  load;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   data;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  zero;
    logic                  done;

    modport master (
        output tick, load, start, pause, data,
        input  count, running, zero, done
    );

    modport slave (
        input  tick, load, start, pause, data,
        output count, running, zero, done
    );
endinterface

// File: rtl/bcd_countdown.sv
// -----------------------------------------------------------------------------
// bcd_countdown
// Multi-digit BCD down-counter / countdown timer. A start value is loaded as
// packed BCD, decremented once per honoured tick with digit-to-digit borrow,
// and expiry is flagged by a one-cycle done pulse.
// Ports:
//   clk     : rising-edge clock
//   clear_  : asynchronous active-low reset
//   bus     : bcd_countdown_if.slave
//             tick/load/start/pause/data in, count/running/zero/done out
// Input priority within a cycle: load > pause > start > tick.
// -----------------------------------------------------------------------------
module bcd_countdown #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              clear_,
    bcd_countdown_if.slave    bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   count_q;
    logic           running_q;
    logic           done_q;

    // Clamp any non-decimal digit (A-F) to 9 so the count is always valid BCD.
    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Decrement by one with BCD borrow: a 0 digit becomes 9 and passes the
    // borrow on; the first non-zero digit absorbs it. Only called with a
    // non-zero operand, so it never wraps below zero.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W-1:0] count_dec;
    assign count_dec = bcd_dec(count_q);

    // NOTE: all state lives in this one clocked block and is updated with
    // non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            // NOTE: every register, including the count itself, is reset so
            // the outputs are defined the instant clear_ goes low.
            state     <= IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                count_q   <= sanitize(bus.data);
                state     <= IDLE;
                running_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A zero count has nothing to time, so start is refused.
                        if (bus.start && (count_q != '0)) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state     <= HOLD;
                            running_q <= 1'b0;
                        end else if (bus.tick) begin
                            count_q <= count_dec;
                            if (count_dec == '0) begin
                                state     <= EXPIRED;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        // pause outranks start, so both together keep us held.
                        if (!bus.pause && bus.start) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    EXPIRED: begin
                        state <= EXPIRED;
                    end
                    default: begin
                        state     <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.zero    = (count_q == '0);

endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Multi-digit BCD down-counter and countdown timer: the count-down complement of the up-counting BCD digit counter and terminal-count counter already in the design. A start value is loaded as packed BCD digits. The block decrements once per qualified `tick` with BCD borrow propagation across digits, and flags expiry with a one-cycle `done` pulse. It sits between the timebase tick generator and the seven-segment display path, and feeds the reaction/countdown control logic.

## Interface

Parameters:
- `DIGITS`, default 4: number of cascaded BCD digits. Legal range 1–8.

Ports:
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `clear_` input, 1 bit: reset, asynchronous and active-low.
- `tick` input, 1 bit: count strobe, one `clk` cycle wide, from the timebase.
- `load` input, 1 bit: load `data` into the count.
- `start` input, 1 bit: begin or resume counting.
- `pause` input, 1 bit: suspend counting.
- `data` input, 4*DIGITS bits: start value, packed BCD. Digit 0 is `data[3:0]` (least significant).
- `count` output, 4*DIGITS bits: current value, packed BCD, same digit order as `data`.
- `running` output, 1 bit: high while in RUN.
- `zero` output, 1 bit: high when every digit of `count` is 0.
- `done` output, 1 bit: one-cycle expiry pulse.

## Operation

- States: IDLE, RUN, HOLD, EXPIRED.
- Reset (`clear_` low) takes effect immediately, independent of `clk`, including mid-count. Reset values:
  - state = IDLE
  - `count` = 0
  - `running` = 0
  - `zero` = 1
  - `done` = 0
- Input priority within a cycle, highest first: `load`, `pause`, `start`, `tick`.
- `load`, in any state:
  - `count` takes sanitized `data`: any digit greater than 9 is forced to 9.
  - State goes to IDLE and `done` is 0.
- IDLE:
  - `start` with `count` ≠ 0 moves to RUN.
  - `start` with `count` = 0 is ignored and the state stays IDLE.
  - `tick` and `pause` are ignored.
- RUN, on `tick`:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - A borrow into a digit that is at 0 continues upward to the following digit.
  - If the decremented value is all zeros, the state moves to EXPIRED and `done` is 1 for the next cycle.
- RUN, on `pause`: moves to HOLD. A `tick` in the same cycle is dropped.
- HOLD:
  - `count` is frozen and `tick` is ignored.
  - `start` returns to RUN.
  - If `pause` and `start` are both high, `pause` wins and the state stays HOLD.
- EXPIRED:
  - `count` stays 0.
  - `tick`, `start` and `pause` are ignored.
  - Only `load` or reset leaves this state.
- Arithmetic:
  - Digits never leave the range 0–9.
  - There is no wrap below zero. The block does not decrement from all zeros.
- Outputs:
  - `running` = (state == RUN).
  - `zero` is decoded from the registered `count`.
  - `done` is a registered pulse, asserted only on the RUN-to-EXPIRED transition.

## Timing

- `tick`, `load`, `start` and `pause` are sampled on the rising edge of `clk`. `count` and the state update at that same edge (latency 1).
- `done` rises on the same edge where `count` becomes 0 and `zero` rises. `done` falls on the following edge. Pulse width is exactly 1 cycle.
- A `start` accepted at edge N makes `running` high after edge N. The first `tick` honoured is the one sampled at edge N+1.
- Back-to-back `tick`s in consecutive cycles each decrement by one.
- A `load` in the same cycle as the terminal `tick` wins: `count` takes `data` and `done` stays low.
- Deasserting `clear_` has no effect until the next rising edge of `clk`. Inputs sampled on that edge are honoured.

## Test plan

- Reset: hold `clear_` low mid-RUN with `count`=0042. Required: `count`=0000, `zero`=1, `running`=0 and `done`=0 immediately, before any clock edge.
- Borrow chain: DIGITS=4, load 1000, start, 1 tick. Required: `count`=0999. One more tick gives 0998.
- Expiry: load 0003, start, 3 ticks on consecutive cycles. Required:
  - `count` goes 0002, 0001, 0000.
  - `done` is high for exactly 1 cycle, aligned with `zero` rising.
  - Further ticks leave `count`=0000 with no new `done`.
- Pause/resume: load 0010, start, 2 ticks, then `pause` with a simultaneous `tick`. Required: `count`=0008 and HOLD. Then 5 ticks leave it at 0008. Then `start` plus 1 tick gives 0007.
- Sanitizing and zero start: load 0xF0A5. Required: `count`=9095. Load 0000, then start. Required: state stays IDLE, `running`=0, no `done`.
- Priority: in RUN with `count`=0001, assert `load` (`data`=0250) and `tick` together. Required: `count`=0250, IDLE, `done`=0.
